load_store_unit: RTL and testbench

Memory-stage front end between the EX/MEM pipeline register and data_memory. data_memory is word-wide, with combinational read and a synchronous write on the rising edge. This block adds byte and halfword loads (sign- or zero-extended) and byte and halfword stores, using a two-cycle read-modify-write that stalls the pipeline. It detects misaligned or illegal requests and registers load results toward MEM/WB.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// read-modify-write FSM states and the byte-lane mask helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  // Byte lanes touched by an access of the given size at the given lane.
  // A halfword always sits on lanes {lane[1],0} and {lane[1],1}.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane datapath for the load/store unit.
// Ports:
//   rdata         word read from data memory
//   lane          addr[1:0] of the request
//   size          access size encoding
//   unsigned_load zero-extend when 1, sign-extend when 0
//   store_data    store operand (low byte/half used for sub-word stores)
//   load_ext      extracted and extended load value
//   merged        rdata with the target lanes replaced by store_data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  input  logic [31:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [4:0]  shift_amt;
  logic [31:0] shifted;
  logic [31:0] replicated;
  logic [3:0]  mask;

  always_comb begin
    // Halfwords are extracted from their aligned pair of lanes.
    shift_amt = (size == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
    shifted   = rdata >> shift_amt;

    case (size)
      SZ_BYTE: load_ext = {{24{~unsigned_load & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{16{~unsigned_load & shifted[15]}}, shifted[15:0]};
      default: load_ext = rdata;
    endcase

    // Replicating the operand across all lanes lets the mask pick the target.
    case (size)
      SZ_BYTE: replicated = {4{store_data[7:0]}};
      SZ_HALF: replicated = {2{store_data[15:0]}};
      default: replicated = store_data;
    endcase

    mask = lane_mask(size, lane);
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = mask[i] ? replicated[8*i +: 8] : rdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end to a word-wide data memory. Adds byte/halfword
// loads with sign/zero extension and byte/halfword stores through a
// two-cycle read-modify-write, flags illegal requests and registers load
// results toward MEM/WB.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  request handshake; stall while valid & !ready
//   mem_read, mem_write  load / store request
//   size, unsigned_load  access size and extension mode
//   addr, store_data     byte address and store operand
//   load_data/load_valid registered load result and its one-cycle pulse
//   err                  one-cycle pulse for misaligned/illegal requests
//   dmem_*               data memory interface (address always word-aligned)
//
// state  | meaning
// IDLE   | accept a request; loads, word stores and errors finish here
// RMW_WR | write the merged word captured during the sub-word read phase
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  unsigned_load,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  err,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic [DATA_WIDTH-1:0] dmem_read_data
);

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  illegal;
  logic                  is_load;
  logic                  is_store;
  logic                  is_sub_store;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  assign addr_aligned = {addr[ADDR_WIDTH-1:2], 2'b00};

  assign illegal = req_valid &
                   ((size == SZ_ILLEGAL) |
                    (mem_read & mem_write) |
                    ((size == SZ_HALF) & addr[0]) |
                    ((size == SZ_WORD) & (addr[1:0] != 2'b00)));

  assign is_load      = req_valid & mem_read & ~mem_write & ~illegal;
  assign is_store     = req_valid & mem_write & ~mem_read & ~illegal;
  assign is_sub_store = is_store & (size != SZ_WORD);

  lsu_align u_align (
    .rdata         (dmem_read_data),
    .lane          (addr[1:0]),
    .size          (size),
    .unsigned_load (unsigned_load),
    .store_data    (store_data),
    .load_ext      (load_ext),
    .merged        (merged)
  );

  always_comb begin
    state_d         = state_q;
    load_data_d     = load_data_q;
    load_valid_d    = 1'b0;
    err_d           = 1'b0;
    merge_d         = merge_q;
    addr_d          = addr_q;
    req_ready       = 1'b1;
    dmem_write      = 1'b0;
    dmem_address    = '0;
    dmem_write_data = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          dmem_address    = addr_aligned;
          dmem_write_data = store_data;
        end
        err_d = illegal;
        if (is_load) begin
          load_data_d  = load_ext;
          load_valid_d = 1'b1;
        end
        if (is_store && (size == SZ_WORD)) begin
          dmem_write = 1'b1;
        end
        if (is_sub_store) begin
          req_ready = 1'b0;
          merge_d   = merged;
          addr_d    = addr_aligned;
          state_d   = RMW_WR;
        end
      end
      RMW_WR: begin
        // Request inputs are held by upstream but not looked at here.
        dmem_write      = 1'b1;
        dmem_address    = addr_q;
        dmem_write_data = merge_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
      merge_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
      merge_q      <= merge_d;
      addr_q       <= addr_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_load;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        err;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .size            (size),
    .unsigned_load   (unsigned_load),
    .addr            (addr),
    .store_data      (store_data),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .err             (err),
    .dmem_write      (dmem_write),
    .dmem_address    (dmem_address),
    .dmem_write_data (dmem_write_data),
    .dmem_read_data  (dmem_read_data)
  );

  // Data memory stand-in: combinational read, write on rising edge.
  logic [31:0] dmem [0:63];
  logic        clr_mem;
  assign dmem_read_data = dmem[dmem_address[7:2]];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else if (dmem_write) begin
      dmem[dmem_address[7:2]] <= dmem_write_data;
    end
  end

  // Reference model: memory as bytes, plus the expected held load result.
  logic [7:0]  ref_b [0:255];
  logic [31:0] exp_load_data;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    longint v;
    int n;
    n = size_bytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_b[int'(a[7:0]) + i]) << (8 * i));
    if (!uns && n < 4 && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]) & ~3;
    return {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] sd);
    for (int i = 0; i < size_bytes(sz); i++) ref_b[int'(a[7:0]) + i] = 8'(sd >> (8 * i));
  endtask

  // Upstream must hold the request stable while stalled.
  logic        hold_pending = 1'b0;
  logic [38:0] held_req;
  always @(posedge clk) begin
    if (hold_pending) begin
      n_checks++;
      if ({req_valid, mem_read, mem_write, size, unsigned_load, addr} !== held_req) begin
        n_fail++;
        $display("FAIL hold_stable: got %h required %h",
                 {req_valid, mem_read, mem_write, size, unsigned_load, addr}, held_req);
      end
    end
    hold_pending <= req_valid && !req_ready && rst_n;
    held_req     <= {req_valid, mem_read, mem_write, size, unsigned_load, addr[31:0]};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (load_valid && err) begin
        n_fail++;
        $display("FAIL excl_valid_err: got load_valid=%b err=%b required not both", load_valid, err);
      end
    end
  end

  // One request through the DUT, checked against the model cycle by cycle.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd);
    logic ill, ld, st, sub, wst;
    @(negedge clk);
    req_valid     = 1'b1;
    mem_read      = rd;
    mem_write     = wr;
    size          = sz;
    unsigned_load = uns;
    addr          = a;
    store_data    = sd;
    ill = (sz == 2'd3) || (rd && wr) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    ld  = rd && !wr && !ill;
    st  = wr && !rd && !ill;
    sub = st && sz != 2'd2;
    wst = st && sz == 2'd2;
    #1;
    n_checks++;
    if (req_ready !== !sub) begin
      n_fail++; $display("FAIL req_ready a=%0d: got %b required %b", a, req_ready, !sub);
    end
    n_checks++;
    if (dmem_write !== wst) begin
      n_fail++; $display("FAIL dmem_write a=%0d: got %b required %b", a, dmem_write, wst);
    end
    n_checks++;
    if (dmem_address !== {a[31:2], 2'b00}) begin
      n_fail++; $display("FAIL dmem_address: got %h required %h", dmem_address, {a[31:2], 2'b00});
    end
    if (wst) begin
      n_checks++;
      if (dmem_write_data !== sd) begin
        n_fail++; $display("FAIL word_wdata: got %h required %h", dmem_write_data, sd);
      end
    end
    if (ld) exp_load_data = ref_load(a, sz, uns);
    if (st) ref_store(a, sz, sd);
    @(posedge clk); #1;
    n_checks++;
    if (load_valid !== ld) begin
      n_fail++; $display("FAIL load_valid a=%0d: got %b required %b", a, load_valid, ld);
    end
    n_checks++;
    if (err !== ill) begin
      n_fail++; $display("FAIL err a=%0d sz=%0d: got %b required %b", a, sz, err, ill);
    end
    n_checks++;
    if (load_data !== exp_load_data) begin
      n_fail++; $display("FAIL load_data a=%0d sz=%0d: got %h required %h", a, sz, load_data, exp_load_data);
    end
    if (sub) begin
      n_checks++;
      if (dmem_write !== 1'b1 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL rmw_wr_ctrl: got write=%b ready=%b required 1 1", dmem_write, req_ready);
      end
      n_checks++;
      if (dmem_address !== {a[31:2], 2'b00}) begin
        n_fail++; $display("FAIL rmw_addr: got %h required %h", dmem_address, {a[31:2], 2'b00});
      end
      n_checks++;
      if (dmem_write_data !== ref_word(a)) begin
        n_fail++; $display("FAIL rmw_wdata: got %h required %h", dmem_write_data, ref_word(a));
      end
      @(posedge clk); #1;
      n_checks++;
      if (load_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++; $display("FAIL rmw_pulses: got lv=%b err=%b required 0 0", load_valid, err);
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 32'h0) begin
      n_fail++; $display("FAIL idle_outputs: got ready=%b write=%b addr=%h required 1 0 0",
                         req_ready, dmem_write, dmem_address);
    end
    @(posedge clk); #1;
    n_checks++;
    if (load_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL idle_pulses: got lv=%b err=%b required 0 0", load_valid, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_mem = 1'b1;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0;
    unsigned_load = 1'b0; addr = 32'h0; store_data = 32'h0;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h0;
    exp_load_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (load_data !== 32'h0 || load_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs: got ld=%h lv=%b err=%b required 0 0 0", load_data, load_valid, err);
    end
    n_checks++;
    if (req_ready !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 32'h0) begin
      n_fail++; $display("FAIL reset_comb: got ready=%b write=%b addr=%h required 1 0 0",
                         req_ready, dmem_write, dmem_address);
    end
    @(negedge clk);
    rst_n = 1'b1; clr_mem = 1'b0;
  endtask

  task automatic test_word();
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'd20, 32'h11223344);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'd20, 32'h0);
    n_checks++;
    if (load_data !== 32'h11223344) begin
      n_fail++; $display("FAIL lw_20: got %h required %h", load_data, 32'h11223344);
    end
    go_idle();
  endtask

  task automatic test_subword_store();
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'd21, 32'h000000AA);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'd20, 32'h0);
    n_checks++;
    if (load_data !== 32'h1122AA44) begin
      n_fail++; $display("FAIL sb_then_lw: got %h required %h", load_data, 32'h1122AA44);
    end
    go_idle();
  endtask

  task automatic test_loads();
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'd21, 32'h0);
    n_checks++;
    if (load_data !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_21: got %h required FFFFFFAA", load_data); end
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'd21, 32'h0);
    n_checks++;
    if (load_data !== 32'h000000AA) begin n_fail++; $display("FAIL lbu_21: got %h required 000000AA", load_data); end
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'd22, 32'h0);
    n_checks++;
    if (load_data !== 32'h00001122) begin n_fail++; $display("FAIL lh_22: got %h required 00001122", load_data); end
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'd20, 32'h0);
    n_checks++;
    if (load_data !== 32'hFFFFAA44) begin n_fail++; $display("FAIL lh_20: got %h required FFFFAA44", load_data); end
    go_idle();
  endtask

  task automatic test_illegal();
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'd23, 32'h0000BEEF);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'd26, 32'h0);
    issue(1'b1, 1'b1, 2'd0, 1'b0, 32'd20, 32'h0);
    issue(1'b1, 1'b0, 2'd3, 1'b0, 32'd20, 32'h0);
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'd20, 32'h0);
    go_idle();
    n_checks++;
    if (dmem[5] !== 32'h1122AA44) begin
      n_fail++; $display("FAIL illegal_mem: got %h required 1122AA44", dmem[5]);
    end
  endtask

  task automatic test_rmw_reset();
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd0;
    unsigned_load = 1'b0; addr = 32'd20; store_data = 32'h00000055;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_stall: got %b required 0", req_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (dmem_write !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_enter: got %b required 1", dmem_write); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_abort_write: got %b required 0", dmem_write); end
    exp_load_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_write = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || load_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_idle: got ready=%b ld=%h required 1 0", req_ready, load_data);
    end
    n_checks++;
    if (dmem[5] !== 32'h1122AA44) begin n_fail++; $display("FAIL rst_mem: got %h required 1122AA44", dmem[5]); end
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'd20, 32'h0);
    go_idle();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'd22, 32'h0000BEEF);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'd20, 32'h0);
    n_checks++;
    if (load_data !== 32'hBEEFAA44) begin
      n_fail++; $display("FAIL b2b_sh_lw: got %h required BEEFAA44", load_data);
    end
    go_idle();
  endtask

  task automatic test_random();
    int r, op;
    logic rd, wr;
    logic [1:0] sz;
    for (int k = 0; k < 120; k++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 9) ? 2'(r % 3) : 2'd3;
      op = $urandom_range(0, 7);
      rd = (op == 1) || (op >= 2 && op <= 4);
      wr = (op == 1) || (op >= 5);
      issue(rd, wr, sz, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 7) == 0) go_idle();
    end
    for (int w = 0; w < 16; w++) issue(1'b1, 1'b0, 2'd2, 1'b0, 32'(4 * w), 32'h0);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_illegal();
    test_rmw_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
